// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array feeder: array size, sequence
// lengths, controller state encoding and the operand skew helper.
package systolic_feeder_pkg;

   localparam int N            = 8;
   localparam int FEED_STEPS   = 22;
   localparam int FLUSH_CYCLES = 16;
   localparam int READ_CYCLES  = 9;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      FLUSH,
      READ
   } state_t;

   // Skewed operand byte for one FEED cycle.
   // phase 0 (B half): bit j = B[step-j][j]
   // phase 1 (A half): bit i = A[i][step-i]
   // Matrices are flattened row-major: element [r][c] sits at bit r*N+c.
   function automatic logic [N-1:0] feed_byte(input logic [N*N-1:0] a_bits,
                                              input logic [N*N-1:0] b_bits,
                                              input logic [4:0]     step,
                                              input logic           phase);
      logic [N-1:0] v;
      int           k;
      v = '0;
      for (int p = 0; p < N; p++) begin
         k = int'(step) - p;
         if (k >= 0 && k < N) begin
            v[p] = phase ? a_bits[p*N + k] : b_bits[k*N + p];
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/systolic_feeder_bit_matrix_bank.sv
// bit_matrix_bank: N x N bit storage.
// Ports:
//   clk, reset          clock, async active-high reset (clears all bits)
//   wr_en/wr_addr/wr_data  one row write port
//   rd_addr/rd_data     combinational row read port
//   bits                all N*N bits, row-major (element [r][c] at r*N+c)
module bit_matrix_bank
   import systolic_feeder_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [$clog2(N)-1:0] wr_addr,
   input  logic [N-1:0]         wr_data,
   input  logic [$clog2(N)-1:0] rd_addr,
   output logic [N-1:0]         rd_data,
   output logic [N*N-1:0]       bits
);

   logic [N-1:0] mem [N];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < N; r++) begin
            mem[r] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

   always_comb begin
      bits = '0;
      for (int r = 0; r < N; r++) begin
         bits[r*N +: N] = mem[r];
      end
   end

endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: sequences an external bit-serial OR/AND systolic array to
// compute C[i][j] = OR_k (A[i][k] & B[k][j]).
// Ports:
//   clk, reset                  clock, async active-high reset
//   wr_en/wr_sel/wr_addr/wr_data host writes to operand bank A (sel=0) or B (sel=1)
//   start                       request a multiply (ignored while busy)
//   busy, done                  run in progress / one-cycle completion pulse
//   rd_addr, rd_data            combinational read of result row
//   arr_clear, arr_data, arr_readout  array controls and operand stream
//   arr_res                     array bottom-row output, captured during READ
//
// state | meaning
// IDLE  | waiting for start; host may write operands
// CLEAR | one cycle, array accumulators cleared
// FEED  | 22 steps x 2 cycles, B half then A half of each step
// FLUSH | 16 cycles, let partial results drain through the array
// READ  | 9 cycles with readout high; cycles 2..9 capture rows 7..0
module systolic_feeder #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_en,
   input  logic         wr_sel,
   input  logic [2:0]   wr_addr,
   input  logic [N-1:0] wr_data,
   input  logic         start,
   output logic         busy,
   output logic         done,
   input  logic [2:0]   rd_addr,
   output logic [N-1:0] rd_data,
   output logic         arr_clear,
   output logic [N-1:0] arr_data,
   output logic         arr_readout,
   input  logic [N-1:0] arr_res
);

   import systolic_feeder_pkg::*;

   localparam logic [5:0] FEED_LAST = 6'(2*FEED_STEPS - 1);

   state_t         state;
   logic [5:0]     feed_cnt;
   logic [5:0]     feed_nxt;
   logic [3:0]     timer;
   logic [N*N-1:0] a_bits;
   logic [N*N-1:0] b_bits;
   logic [N-1:0]   a_row_unused;
   logic [N-1:0]   b_row_unused;
   logic [N*N-1:0] res_bits_unused;
   logic           op_wr;
   logic           res_wr;

   // Operands are only writable in IDLE so a run sees a frozen snapshot;
   // a write coinciding with an accepted start still lands before CLEAR.
   assign op_wr    = wr_en && (state == IDLE);
   // READ timer counts 8..0; values 7..0 are capture cycles and equal the row.
   assign res_wr   = (state == READ) && (timer < 4'(N));
   assign feed_nxt = feed_cnt + 6'd1;

   bit_matrix_bank u_bank_a (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (op_wr && !wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (wr_addr),
      .rd_data (a_row_unused),
      .bits    (a_bits)
   );

   bit_matrix_bank u_bank_b (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (op_wr && wr_sel),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (wr_addr),
      .rd_data (b_row_unused),
      .bits    (b_bits)
   );

   bit_matrix_bank u_bank_res (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (res_wr),
      .wr_addr (timer[2:0]),
      .wr_data (arr_res),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .bits    (res_bits_unused)
   );

   // Outputs are registered for the state being entered, so arr_data for a
   // FEED cycle is computed from the counter value that cycle will hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         feed_cnt    <= '0;
         timer       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         arr_clear   <= 1'b0;
         arr_data    <= '0;
         arr_readout <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= CLEAR;
                  busy      <= 1'b1;
                  arr_clear <= 1'b1;
               end
            end
            CLEAR: begin
               state     <= FEED;
               arr_clear <= 1'b0;
               feed_cnt  <= '0;
               arr_data  <= feed_byte(a_bits, b_bits, 5'd0, 1'b0);
            end
            FEED: begin
               if (feed_cnt == FEED_LAST) begin
                  state    <= FLUSH;
                  feed_cnt <= '0;
                  timer    <= 4'(FLUSH_CYCLES - 1);
                  arr_data <= '0;
               end else begin
                  feed_cnt <= feed_nxt;
                  arr_data <= feed_byte(a_bits, b_bits, feed_nxt[5:1], feed_nxt[0]);
               end
            end
            FLUSH: begin
               if (timer == 4'd0) begin
                  state       <= READ;
                  timer       <= 4'(READ_CYCLES - 1);
                  arr_readout <= 1'b1;
               end else begin
                  timer <= timer - 4'd1;
               end
            end
            READ: begin
               if (timer == 4'd0) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  arr_readout <= 1'b0;
                  done        <= 1'b1;
               end else begin
                  timer <= timer - 4'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 SHALL have parameter N, default 8, meaning array dimension (rows = columns = bits per word); only N=8 is required to work.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state.
REQ-004 wr_en  in  1  host write strobe for the operand banks.
REQ-005 wr_sel  in  1  operand bank select, 0 = A, 1 = B.
REQ-006 wr_addr  in  3  operand row index.
REQ-007 wr_data  in  8  operand row; bit k of A row i = A[i][k].
REQ-008 start  in  1  one-cycle request to run a multiply.
REQ-009 busy  out  1  high from the cycle after an accepted start until done.
REQ-010 done  out  1  one-cycle pulse when results are valid.
REQ-011 rd_addr  in  3  result row index.
REQ-012 rd_data  out  8  combinational read of result row rd_addr; bit j = C[i][j].
REQ-013 arr_clear  out  1  tied to the array's active-high synchronous reset input.
REQ-014 arr_data  out  8  interleaved operand byte stream to the array input.
REQ-015 arr_readout  out  1  array readout control.
REQ-016 arr_res  in  8  array bottom-row output.

Function
REQ-017 SHALL compute C[i][j] = OR over k of (A[i][k] AND B[k][j]) using the external bit-serial OR/AND systolic array.
REQ-018 SHALL implement states IDLE, CLEAR, FEED, FLUSH, READ.
- IDLE -> CLEAR on start.
- CLEAR lasts 1 cycle.
- FEED lasts 44 cycles.
- FLUSH lasts 16 cycles.
- READ lasts 9 cycles, then returns to IDLE.
REQ-019 SHALL assert arr_clear only in CLEAR, so array accumulators clear and its 2-cycle input phase aligns with FEED cycle 0.
REQ-020 FEED SHALL run 22 steps s = 0..21 of 2 cycles each.
- First cycle of a step: arr_data bit j = B[s-j][j] if 0 <= s-j < 8, else 0.
- Second cycle of a step: arr_data bit i = A[i][s-i] if 0 <= s-i < 8, else 0.
REQ-021 arr_data SHALL be 0 in every state except FEED.
REQ-022 arr_readout SHALL be high exactly in READ.
REQ-023 In READ cycles 2..9, SHALL capture arr_res into result row 7-(c-2), where c is the READ cycle number; first capture is row 7, last is row 0.
REQ-024 done SHALL pulse in the first IDLE cycle after READ, i.e. 71 cycles after the start cycle.
REQ-025 busy SHALL be high in CLEAR, FEED, FLUSH and READ.
REQ-026 start while busy SHALL be ignored (no restart, no queueing).
REQ-027 wr_en while busy SHALL be ignored; operand banks stay frozen during a run.
REQ-028 Simultaneous wr_en and start in IDLE SHALL commit the write first; the run uses the new row.
REQ-029 rd_data SHALL return the previous run's results until the READ captures of a new run overwrite each row.
REQ-030 Row addresses SHALL use all 3 bits; there is no out-of-range case and no wrap logic.

Reset
REQ-031 On reset, SHALL set:
- state = IDLE, step and cycle counters = 0;
- A, B and result banks = 0;
- busy = 0, done = 0, arr_clear = 0, arr_data = 0, arr_readout = 0.
REQ-032 Reset mid-run SHALL abort immediately, without a done pulse, leaving rd_data = 0 for all rows.

Structure
REQ-033 SHALL place the following in a shared package: N, FEED_STEPS = 22, FLUSH_CYCLES = 16, READ_CYCLES = 9, and the state enumeration.
REQ-034 SHALL use one sub-module, bit_matrix_bank: 8x8 flops, one write port, one row-read port, and all 64 bits exposed; instantiated for A, B and the result bank.

Verification
REQ-035 Bench SHALL cover these directed scenarios:
- A = B = identity (row i = 1<<i), start -> done at cycle 71; rd_data[i] = 1<<i.
- A all-zero, B all-ones -> all result rows 0x00.
- A all rows 0x01, B row0 = 0x5A, other B rows 0x00 -> every result row 0x5A.
- start pulsed again at FEED cycle 10, plus wr_en to A -> single done at cycle 71; result matches the original A.
- reset asserted at FEED cycle 20 -> busy, arr_readout and arr_data go 0 asynchronously; no done; all rd_data 0x00.
- Two back-to-back runs with different operands -> second results fully replace the first; arr_clear pulses once per run.
